// File: rtl/dot_mvm_sequencer.sv
// Control sequencer for the axis_dot matrix-vector engine: loads the input vector,
// issues one MAC op per cycle per row, waits out the pipeline and hands each row result downstream.
module dot_mvm_sequencer #(
  parameter  int N_IN    = 20,
  parameter  int N_OUT   = 10,
  parameter  int RD_LAT  = 1,
  parameter  int MAC_LAT = 4,
  localparam int AW_IN   = $clog2(N_IN),
  localparam int AW_W    = $clog2(N_IN*N_OUT),
  localparam int AW_R    = $clog2(N_OUT)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             INPUT_AXIS_TVALID,
  input  logic             INPUT_AXIS_TLAST,
  output logic             INPUT_AXIS_TREADY,
  output logic             vec_wr_en,
  output logic [AW_IN-1:0] vec_wr_addr,
  output logic [AW_IN-1:0] vec_rd_addr,
  output logic [AW_W-1:0]  wgt_rd_addr,
  output logic             mac_valid,
  output logic             mac_first,
  output logic             res_capture,
  output logic             OUTPUT_AXIS_TVALID,
  output logic             OUTPUT_AXIS_TLAST,
  input  logic             OUTPUT_AXIS_TREADY,
  output logic [AW_R-1:0]  row_idx,
  output logic             err_len
);

  // state   | meaning
  // S_INIT  | first cycle after reset release, all outputs idle
  // S_LOAD  | accept input vector words into the vector buffer
  // S_ISSUE | one MAC operand read per cycle, col 0..N_IN-1
  // S_DRAIN | wait out read + MAC latency, capture result in last cycle
  // S_OUT   | present row result until downstream accepts it
  typedef enum logic [2:0] {S_INIT, S_LOAD, S_ISSUE, S_DRAIN, S_OUT} state_t;

  localparam int DW = $clog2(RD_LAT + MAC_LAT + 1);

  state_t            state_q, state_d;
  logic [AW_IN-1:0]  word_cnt_q, word_cnt_d;
  logic [AW_IN-1:0]  col_q, col_d;
  logic [AW_W-1:0]   wgt_q, wgt_d;
  logic [AW_R-1:0]   row_q, row_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0] first_sr_q, first_sr_d;

  logic issue, issue_first, word_last, len_bad;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_INIT;
      word_cnt_q <= '0;
      col_q      <= '0;
      wgt_q      <= '0;
      row_q      <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
      vld_sr_q   <= '0;
      first_sr_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      col_q      <= col_d;
      wgt_q      <= wgt_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      vld_sr_q   <= vld_sr_d;
      first_sr_q <= first_sr_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    word_cnt_d         = word_cnt_q;
    col_d              = col_q;
    wgt_d              = wgt_q;
    row_d              = row_q;
    drain_d            = drain_q;
    err_d              = err_q;
    INPUT_AXIS_TREADY  = 1'b0;
    vec_wr_en          = 1'b0;
    res_capture        = 1'b0;
    OUTPUT_AXIS_TVALID = 1'b0;
    OUTPUT_AXIS_TLAST  = 1'b0;
    issue              = 1'b0;
    issue_first        = 1'b0;
    word_last          = (word_cnt_q == AW_IN'(N_IN - 1));
    len_bad            = (INPUT_AXIS_TLAST != word_last);

    case (state_q)
      S_INIT: state_d = S_LOAD;

      S_LOAD: begin
        INPUT_AXIS_TREADY = 1'b1;
        if (INPUT_AXIS_TVALID) begin
          vec_wr_en = 1'b1;
          // the first word of a frame restarts the sticky length error
          err_d = (word_cnt_q == '0) ? len_bad : (err_q | len_bad);
          if (word_last) begin
            word_cnt_d = '0;
            col_d      = '0;
            row_d      = '0;
            state_d    = S_ISSUE;
          end else begin
            word_cnt_d = word_cnt_q + AW_IN'(1);
          end
        end
      end

      S_ISSUE: begin
        issue       = 1'b1;
        issue_first = (col_q == '0);
        wgt_d       = (wgt_q == AW_W'(N_IN*N_OUT - 1)) ? '0 : wgt_q + AW_W'(1);
        if (col_q == AW_IN'(N_IN - 1)) begin
          col_d   = '0;
          drain_d = DW'(RD_LAT + MAC_LAT - 1);
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + AW_IN'(1);
        end
      end

      S_DRAIN: begin
        if (drain_q == '0) begin
          res_capture = 1'b1;
          state_d     = S_OUT;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end

      S_OUT: begin
        OUTPUT_AXIS_TVALID = 1'b1;
        OUTPUT_AXIS_TLAST  = (row_q == AW_R'(N_OUT - 1));
        if (OUTPUT_AXIS_TREADY) begin
          if (OUTPUT_AXIS_TLAST) begin
            row_d   = '0;
            state_d = S_LOAD;
          end else begin
            row_d   = row_q + AW_R'(1);
            state_d = S_ISSUE;
          end
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // operand-valid and accumulator-clear follow the addresses by RD_LAT cycles
  always_comb begin
    vld_sr_d      = vld_sr_q;
    first_sr_d    = first_sr_q;
    vld_sr_d[0]   = issue;
    first_sr_d[0] = issue_first;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i]   = vld_sr_q[i-1];
      first_sr_d[i] = first_sr_q[i-1];
    end
  end

  assign vec_wr_addr = word_cnt_q;
  assign vec_rd_addr = col_q;
  assign wgt_rd_addr = wgt_q;
  assign mac_valid   = vld_sr_q[RD_LAT-1];
  assign mac_first   = vld_sr_q[RD_LAT-1] & first_sr_q[RD_LAT-1];
  assign row_idx     = row_q;
  assign err_len     = err_q;

endmodule

// File: tb/tb_dot_mvm_sequencer.sv
// Directed self-checking bench for dot_mvm_sequencer: reset, load, full frame timing,
// output stall, length-error flag and mid-frame reset.
module tb_dot_mvm_sequencer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       in_tvalid = 1'b0;
  logic       in_tlast = 1'b0;
  logic       in_tready;
  logic       vec_wr_en;
  logic [4:0] vec_wr_addr;
  logic [4:0] vec_rd_addr;
  logic [7:0] wgt_rd_addr;
  logic       mac_valid;
  logic       mac_first;
  logic       res_capture;
  logic       out_tvalid;
  logic       out_tlast;
  logic       out_tready = 1'b1;
  logic [3:0] row_idx;
  logic       err_len;

  int n_pass  = 0;
  int n_total = 0;
  int cap_cnt [0:15];

  logic [29:0] all_outs;
  assign all_outs = {in_tready, vec_wr_en, vec_wr_addr, vec_rd_addr, wgt_rd_addr, mac_valid,
                     mac_first, res_capture, out_tvalid, out_tlast, row_idx, err_len};

  dot_mvm_sequencer dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .INPUT_AXIS_TVALID  (in_tvalid),
    .INPUT_AXIS_TLAST   (in_tlast),
    .INPUT_AXIS_TREADY  (in_tready),
    .vec_wr_en          (vec_wr_en),
    .vec_wr_addr        (vec_wr_addr),
    .vec_rd_addr        (vec_rd_addr),
    .wgt_rd_addr        (wgt_rd_addr),
    .mac_valid          (mac_valid),
    .mac_first          (mac_first),
    .res_capture        (res_capture),
    .OUTPUT_AXIS_TVALID (out_tvalid),
    .OUTPUT_AXIS_TLAST  (out_tlast),
    .OUTPUT_AXIS_TREADY (out_tready),
    .row_idx            (row_idx),
    .err_len            (err_len)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (aresetn && res_capture) cap_cnt[row_idx] = cap_cnt[row_idx] + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic clear_caps();
    for (int i = 0; i < 16; i++) cap_cnt[i] = 0;
  endtask

  // stimulus only: 20 back-to-back words, returns on the first ISSUE cycle
  task automatic send_frame(input int tlast_pos);
    for (int i = 0; i < 20; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = (i == tlast_pos);
      @(negedge aclk);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (in_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    in_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (i % 5 == 4) begin
        n_total++;
        if (all_outs !== 30'd0) $display("FAIL reset_outs: got %h want 0", all_outs);
        else n_pass++;
      end
    end
    in_tvalid = 1'b0;
    aresetn   = 1'b1;
    #1;
    n_total++;
    if (in_tready !== 1'b0) $display("FAIL reset_tready_at_release: got %b want 0", in_tready);
    else n_pass++;
    @(negedge aclk);
    n_total++;
    if (in_tready !== 1'b1) $display("FAIL reset_tready_after_edge: got %b want 1", in_tready);
    else n_pass++;
    n_total++;
    if ({vec_wr_addr, row_idx, err_len} !== 10'd0)
      $display("FAIL reset_counters: got %h want 0", {vec_wr_addr, row_idx, err_len});
    else n_pass++;
  endtask

  task automatic test_load();
    bit ok;
    for (int i = 0; i < 20; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = (i == 19);
      #1;
      n_total++;
      if ({in_tready, vec_wr_en, vec_wr_addr} !== {1'b1, 1'b1, 5'(i)})
        $display("FAIL load_word%0d: got rdy/en/addr %b/%b/%0d want 1/1/%0d",
                 i, in_tready, vec_wr_en, vec_wr_addr, i);
      else n_pass++;
      @(negedge aclk);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    n_total++;
    if ({in_tready, err_len} !== 2'b00)
      $display("FAIL load_after_last: got tready/err %b/%b want 0/0", in_tready, err_len);
    else n_pass++;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        n_total++;
        if ({wgt_rd_addr, vec_rd_addr} !== {8'(i), 5'(i)})
          $display("FAIL issue_addr_col%0d: got wgt/vec %0d/%0d want %0d/%0d",
                   i, wgt_rd_addr, vec_rd_addr, i, i);
        else n_pass++;
      end
      n_total++;
      if ({mac_valid, mac_first} !== {(i >= 1), (i == 1)})
        $display("FAIL issue_mac_cyc%0d: got valid/first %b/%b want %b/%b",
                 i, mac_valid, mac_first, (i >= 1), (i == 1));
      else n_pass++;
      @(negedge aclk);
    end
    wait_load(ok);
    n_total++;
    if (!ok) $display("FAIL load_frame_done: got timeout want return to LOAD");
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int beats = 0;
    int maxw  = 0;
    clear_caps();
    out_tready = 1'b1;
    send_frame(19);
    for (int t = 0; t < 320 && beats < 10; t++) begin
      if (int'(wgt_rd_addr) > maxw) maxw = int'(wgt_rd_addr);
      if (out_tvalid === 1'b1) begin
        n_total++;
        if (t != 25 + 26*beats || out_tlast !== (beats == 9))
          $display("FAIL frame_beat%0d: got cycle %0d tlast %b want cycle %0d tlast %b",
                   beats, t, out_tlast, 25 + 26*beats, (beats == 9));
        else n_pass++;
        beats++;
      end
      @(negedge aclk);
    end
    n_total++;
    if (beats != 10) $display("FAIL frame_beats: got %0d want 10", beats);
    else n_pass++;
    n_total++;
    if (maxw != 199) $display("FAIL frame_last_wgt: got %0d want 199", maxw);
    else n_pass++;
    n_total++;
    if ({in_tready, wgt_rd_addr, row_idx} !== {1'b1, 8'd0, 4'd0})
      $display("FAIL frame_back_to_load: got tready/wgt/row %b/%0d/%0d want 1/0/0",
               in_tready, wgt_rd_addr, row_idx);
    else n_pass++;
    n_total++;
    if (cap_cnt[0] != 1 || cap_cnt[9] != 1)
      $display("FAIL frame_captures: got row0 %0d row9 %0d want 1 1", cap_cnt[0], cap_cnt[9]);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    bit found = 1'b0;
    clear_caps();
    out_tready = 1'b1;
    send_frame(19);
    for (int t = 0; t < 200; t++) begin
      if (out_tvalid === 1'b1 && row_idx == 4'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    n_total++;
    if (!found) $display("FAIL stall_find_row3: got timeout want row 3 beat");
    else n_pass++;
    out_tready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge aclk);
      n_total++;
      if ({out_tvalid, out_tlast, row_idx, mac_valid, res_capture} !== {1'b1, 1'b0, 4'd3, 1'b0, 1'b0})
        $display("FAIL stall_hold%0d: got tv/tl/row/mv/cap %b/%b/%0d/%b/%b want 1/0/3/0/0",
                 i, out_tvalid, out_tlast, row_idx, mac_valid, res_capture);
      else n_pass++;
    end
    out_tready = 1'b1;
    @(negedge aclk);
    n_total++;
    if ({out_tvalid, row_idx, mac_valid} !== {1'b0, 4'd4, 1'b0})
      $display("FAIL stall_after_hs: got tv/row/mv %b/%0d/%b want 0/4/0", out_tvalid, row_idx, mac_valid);
    else n_pass++;
    @(negedge aclk);
    n_total++;
    if ({mac_valid, mac_first} !== 2'b11)
      $display("FAIL stall_row4_first_mac: got valid/first %b/%b want 1/1", mac_valid, mac_first);
    else n_pass++;
    wait_load(ok);
    n_total++;
    if (!ok) $display("FAIL stall_frame_done: got timeout want return to LOAD");
    else n_pass++;
    n_total++;
    if (cap_cnt[3] != 1 || cap_cnt[4] != 1)
      $display("FAIL stall_captures: got row3 %0d row4 %0d want 1 1", cap_cnt[3], cap_cnt[4]);
    else n_pass++;
  endtask

  task automatic test_err_len();
    bit ok;
    for (int i = 0; i < 20; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = (i == 5);
      #1;
      if (i == 12) begin
        n_total++;
        if (in_tready !== 1'b1) $display("FAIL err_still_loading: got %b want 1", in_tready);
        else n_pass++;
      end
      @(negedge aclk);
      if (i == 4 || i == 5) begin
        n_total++;
        if (err_len !== (i == 5)) $display("FAIL err_word%0d: got %b want %b", i, err_len, (i == 5));
        else n_pass++;
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    n_total++;
    if ({in_tready, err_len} !== 2'b01)
      $display("FAIL err_frame_complete: got tready/err %b/%b want 0/1", in_tready, err_len);
    else n_pass++;
    wait_load(ok);
    n_total++;
    if (!ok || err_len !== 1'b1) $display("FAIL err_sticky: got ok/err %b/%b want 1/1", ok, err_len);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = 1'b0;
      @(negedge aclk);
      if (i == 0 || i == 18 || i == 19) begin
        n_total++;
        if (err_len !== (i == 19)) $display("FAIL err_next_word%0d: got %b want %b", i, err_len, (i == 19));
        else n_pass++;
      end
    end
    in_tvalid = 1'b0;
    wait_load(ok);
    n_total++;
    if (!ok) $display("FAIL err_frame2_done: got timeout want return to LOAD");
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit found = 1'b0;
    send_frame(19);
    for (int t = 0; t < 200; t++) begin
      if (mac_valid === 1'b1 && row_idx == 4'd4 && vec_rd_addr == 5'd6) begin
        found = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    n_total++;
    if (!found) $display("FAIL mrst_find_row4: got timeout want row 4 issue");
    else n_pass++;
    aresetn = 1'b0;
    #1;
    n_total++;
    if (all_outs !== 30'd0) $display("FAIL mrst_outs_zero: got %h want 0", all_outs);
    else n_pass++;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_total++;
    if ({in_tready, vec_wr_addr, row_idx} !== {1'b1, 5'd0, 4'd0})
      $display("FAIL mrst_load: got tready/addr/row %b/%0d/%0d want 1/0/0", in_tready, vec_wr_addr, row_idx);
    else n_pass++;
    in_tvalid = 1'b1;
    #1;
    n_total++;
    if ({vec_wr_en, vec_wr_addr} !== {1'b1, 5'd0})
      $display("FAIL mrst_first_word: got en/addr %b/%0d want 1/0", vec_wr_en, vec_wr_addr);
    else n_pass++;
    @(negedge aclk);
    in_tvalid = 1'b0;
    for (int i = 1; i < 20; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = (i == 19);
      @(negedge aclk);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    n_total++;
    if ({wgt_rd_addr, vec_rd_addr, row_idx, mac_valid} !== {8'd0, 5'd0, 4'd0, 1'b0})
      $display("FAIL mrst_issue_start: got wgt/vec/row/mv %0d/%0d/%0d/%b want 0/0/0/0",
               wgt_rd_addr, vec_rd_addr, row_idx, mac_valid);
    else n_pass++;
    @(negedge aclk);
    n_total++;
    if ({mac_valid, mac_first, wgt_rd_addr} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL mrst_first_mac: got mv/mf/wgt %b/%b/%0d want 1/1/1", mac_valid, mac_first, wgt_rd_addr);
    else n_pass++;
    wait_load(ok);
    n_total++;
    if (!ok) $display("FAIL mrst_frame_done: got timeout want return to LOAD");
    else n_pass++;
  endtask

  initial begin
    clear_caps();
    test_reset();
    test_load();
    test_full_frame();
    test_stall();
    test_err_len();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
